// File: rtl/invalid_data_gen.sv
// invalid_data_gen: key-gated data path. Beats pass in clear only while
// unlocked; otherwise they are XORed with an LFSR-derived dummy word.
// Too many wrong keys latch the block into BLOCKED until reset.
module invalid_data_gen #(
  parameter int unsigned WIDTH     = 64,
  parameter logic [63:0] KEY       = 64'h0,
  parameter logic [31:0] SEED      = 32'hACE1_0001,
  parameter int unsigned MAX_FAILS = 3,
  parameter bit          INV_UPPER = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [63:0]      KeyIn,
  input  logic             KeyValid,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] DataOut,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Unlocked,
  output logic             Blocked
);

  localparam int unsigned LFSR_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned REPS   = WIDTH / LFSR_W;
  localparam int unsigned HALF   = WIDTH / 2;

  // Taps for x^32 + x^22 + x^2 + x + 1 on a left-shifting register.
  localparam logic [LFSR_W-1:0] TAP_MASK    = 32'h8020_0003;
  localparam logic [CNT_W-1:0]  CNT_SAT     = '1;
  localparam logic [CNT_W-1:0]  MAX_FAILS_C = CNT_W'(MAX_FAILS);

  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_UNLOCKED = 2'd1;
  localparam logic [1:0] ST_BLOCKED  = 2'd2;

  // Reject parameterisations the datapath cannot support.
  if ((WIDTH < LFSR_W) || ((WIDTH % LFSR_W) != 0)) begin : g_bad_width
    $error("invalid_data_gen: WIDTH must be a multiple of 32, at least 32");
  end
  if ((MAX_FAILS < 1) || (MAX_FAILS > 15)) begin : g_bad_fails
    $error("invalid_data_gen: MAX_FAILS must be in 1..15");
  end
  if (SEED == 32'h0) begin : g_bad_seed
    $error("invalid_data_gen: SEED must be nonzero");
  end

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              unlocked_q, blocked_q;

  logic              key_match_c;
  logic [CNT_W-1:0]  fail_inc_c;
  logic              in_ready_c;
  logic              accept_c;
  logic [LFSR_W-1:0] lfsr_next_c;
  logic [WIDTH-1:0]  dummy_c;

  assign key_match_c = (KeyIn == KEY);
  assign fail_inc_c  = (fail_cnt_q == CNT_SAT) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
  assign in_ready_c  = !valid_q || OutReady;
  assign accept_c    = InValid && in_ready_c;
  assign lfsr_next_c = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAP_MASK)};

  // Dummy word: LFSR state tiled across the bus, upper half optionally inverted.
  always_comb begin
    dummy_c = {REPS{lfsr_q}};
    if (INV_UPPER) begin
      dummy_c[WIDTH-1:HALF] = ~dummy_c[WIDTH-1:HALF];
    end
  end

  // Lock FSM next state and fail counter.
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      ST_LOCKED: begin
        if (KeyValid) begin
          if (key_match_c) begin
            state_d = ST_UNLOCKED;
          end else begin
            fail_cnt_d = fail_inc_c;
            state_d    = (fail_inc_c == MAX_FAILS_C) ? ST_BLOCKED : ST_LOCKED;
          end
        end
      end
      ST_UNLOCKED: begin
        if (KeyValid && !key_match_c) begin
          fail_cnt_d = fail_inc_c;
          state_d    = (fail_inc_c == MAX_FAILS_C) ? ST_BLOCKED : ST_LOCKED;
        end
      end
      ST_BLOCKED: begin
        state_d = ST_BLOCKED;
      end
      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  // Output stage and LFSR: load on accept, drop valid once consumed.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    lfsr_d  = lfsr_q;
    if (accept_c) begin
      valid_d = 1'b1;
      if (state_q == ST_UNLOCKED) begin
        data_d = DataIn;
      end else begin
        data_d = DataIn ^ dummy_c;
        lfsr_d = lfsr_next_c;
      end
    end else if (valid_q && OutReady) begin
      valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_LOCKED;
      fail_cnt_q <= '0;
      lfsr_q     <= SEED;
      data_q     <= '0;
      valid_q    <= 1'b0;
      unlocked_q <= 1'b0;
      blocked_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      lfsr_q     <= lfsr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      unlocked_q <= (state_d == ST_UNLOCKED);
      blocked_q  <= (state_d == ST_BLOCKED);
    end
  end

  assign InReady  = in_ready_c;
  assign DataOut  = data_q;
  assign OutValid = valid_q;
  assign Unlocked = unlocked_q;
  assign Blocked  = blocked_q;

endmodule

// File: tb/tb_invalid_data_gen.sv
// Scoreboard bench for invalid_data_gen: a behavioural model pushes the
// expected output of every accepted beat; a monitor pops and compares.
module tb_invalid_data_gen;

  localparam logic [63:0] TB_KEY    = 64'h0123_4567_89AB_CDEF;
  localparam logic [31:0] TB_SEED   = 32'hACE1_0001;
  localparam int unsigned TB_FAILS  = 3;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [63:0] KeyIn = '0;
  logic        KeyValid = 1'b0;
  logic [63:0] DataIn = '0;
  logic        InValid = 1'b0;
  logic        OutReady = 1'b0;

  logic [63:0] data0, data1;
  logic        ir0, ir1, ov0, ov1, unl0, unl1, blk0, blk1;

  int checks = 0;
  int passed = 0;

  always #5 Clk = ~Clk;

  invalid_data_gen #(.WIDTH(64), .KEY(TB_KEY), .SEED(TB_SEED),
                     .MAX_FAILS(TB_FAILS), .INV_UPPER(1'b0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .KeyIn(KeyIn), .KeyValid(KeyValid),
    .DataIn(DataIn), .InValid(InValid), .InReady(ir0), .DataOut(data0),
    .OutValid(ov0), .OutReady(OutReady), .Unlocked(unl0), .Blocked(blk0));

  invalid_data_gen #(.WIDTH(64), .KEY(TB_KEY), .SEED(TB_SEED),
                     .MAX_FAILS(TB_FAILS), .INV_UPPER(1'b1)) dut_inv (
    .Clk(Clk), .Rst_n(Rst_n), .KeyIn(KeyIn), .KeyValid(KeyValid),
    .DataIn(DataIn), .InValid(InValid), .InReady(ir1), .DataOut(data1),
    .OutValid(ov1), .OutReady(OutReady), .Unlocked(unl1), .Blocked(blk1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] e0;
    logic [63:0] e1;
  } exp_t;
  exp_t exp_q[$];

  bit          m_unl = 0;
  bit          m_blk = 0;
  int          m_fails = 0;
  logic [31:0] m_lfsr = TB_SEED;
  bit          m_ov = 0;

  // One LFSR step: polynomial exponents 32, 22, 2, 1 feed the new bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  function automatic logic [63:0] dummy(input logic [31:0] s, input bit inv);
    logic [63:0] d;
    d = {s, s};
    if (inv) d[63:32] = ~d[63:32];
    return d;
  endfunction

  initial forever begin
    @(posedge Clk or negedge Rst_n);
    if (!Rst_n) begin
      m_unl = 0; m_blk = 0; m_fails = 0; m_lfsr = TB_SEED; m_ov = 0;
      exp_q.delete();
    end else begin
      bit   acc;
      exp_t e;
      acc = InValid && (!m_ov || OutReady);
      if (acc) begin
        e.e0 = m_unl ? DataIn : DataIn ^ dummy(m_lfsr, 1'b0);
        e.e1 = m_unl ? DataIn : DataIn ^ dummy(m_lfsr, 1'b1);
        exp_q.push_back(e);
        if (!m_unl) m_lfsr = lfsr_step(m_lfsr);
        m_ov = 1;
      end else if (m_ov && OutReady) begin
        m_ov = 0;
      end
      if (KeyValid && !m_blk) begin
        if (KeyIn == TB_KEY) begin
          m_unl = 1;
        end else begin
          if (m_fails < 15) m_fails++;
          m_unl = 0;
          if (m_fails == TB_FAILS) m_blk = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge Clk);
    check("in_ready",      64'(ir0),  64'(!m_ov || OutReady));
    check("in_ready_inv",  64'(ir1),  64'(!m_ov || OutReady));
    check("out_valid",     64'(ov0),  64'(m_ov));
    check("out_valid_inv", 64'(ov1),  64'(m_ov));
    check("unlocked",      64'(unl0), 64'(m_unl));
    check("blocked",       64'(blk0), 64'(m_blk));
    check("unlocked_inv",  64'(unl1), 64'(m_unl));
    check("blocked_inv",   64'(blk1), 64'(m_blk));
    if (ov0 && exp_q.size() != 0) begin
      check("data_out",     data0, exp_q[0].e0);
      check("data_out_inv", data1, exp_q[0].e1);
      if (OutReady) void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
  endtask

  task automatic random_phase(input int cycles, input int key_ok_pct);
    for (int i = 0; i < cycles; i++) begin
      InValid  = ($urandom_range(0, 3) != 0);
      DataIn   = {$urandom, $urandom};
      OutReady = ($urandom_range(0, 3) != 0);
      KeyValid = ($urandom_range(0, 9) == 0);
      KeyIn    = ($urandom_range(0, 99) < key_ok_pct) ? TB_KEY : {$urandom, $urandom};
      tick();
    end
    InValid = 1'b0; KeyValid = 1'b0;
  endtask

  initial begin
    logic [63:0] a_beat, b_beat;
    a_beat = 64'hAAAA_0000_5555_1111;
    b_beat = 64'hBBBB_2222_6666_3333;

    // Reset values
    repeat (3) tick();
    check("rst_data",     data0, 64'h0);
    check("rst_data_inv", data1, 64'h0);
    check("rst_valid",    64'(ov0), 64'h0);
    check("rst_unlocked", 64'(unl0), 64'h0);
    check("rst_blocked",  64'(blk0), 64'h0);
    Rst_n = 1'b1;

    // Locked path on first edge after reset, both dummy variants
    OutReady = 1'b1; InValid = 1'b1; DataIn = 64'h0;
    tick();
    InValid = 1'b0;
    check("locked_zero",     data0, 64'hACE1_0001_ACE1_0001);
    check("locked_zero_inv", data1, 64'h531E_FFFE_ACE1_0001);
    check("locked_valid",    64'(ov0), 64'h1);

    // Key and beat in the same cycle, then a clear beat
    do_reset();
    KeyValid = 1'b1; KeyIn = TB_KEY; InValid = 1'b1; DataIn = 64'h0;
    tick();
    KeyValid = 1'b0; DataIn = 64'h1234_5678_9ABC_DEF0;
    check("same_cycle_beat", data0, 64'hACE1_0001_ACE1_0001);
    check("same_cycle_unl",  64'(unl0), 64'h1);
    tick();
    InValid = 1'b0;
    check("clear_beat",     data0, 64'h1234_5678_9ABC_DEF0);
    check("clear_beat_inv", data1, 64'h1234_5678_9ABC_DEF0);
    tick();

    // Backpressure: A held three cycles with B waiting
    OutReady = 1'b0; InValid = 1'b1; DataIn = a_beat;
    tick();
    DataIn = b_beat;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data",  data0, a_beat);
      check("bp_in_ready",   64'(ir0), 64'h0);
      tick();
    end
    OutReady = 1'b1;
    tick();
    InValid = 1'b0;
    check("bp_b_out", data0, b_beat);
    tick();

    random_phase(300, 50);

    // Reset while a beat is held
    OutReady = 1'b0; InValid = 1'b1; DataIn = {$urandom, $urandom};
    tick();
    InValid = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    check("midrst_valid",    64'(ov0),  64'h0);
    check("midrst_unlocked", 64'(unl0), 64'h0);
    check("midrst_data",     data0,     64'h0);
    tick();
    Rst_n = 1'b1; OutReady = 1'b1;

    // Three wrong keys block; a correct key afterwards is ignored
    for (int i = 0; i < 3; i++) begin
      KeyValid = 1'b1; KeyIn = ~TB_KEY;
      tick();
    end
    KeyValid = 1'b0;
    check("block_set", 64'(blk0), 64'h1);
    KeyValid = 1'b1; KeyIn = TB_KEY;
    tick();
    KeyValid = 1'b0;
    check("block_no_unlock", 64'(unl0), 64'h0);
    InValid = 1'b1; DataIn = 64'h0;
    tick();
    InValid = 1'b0;
    check("block_obfuscated", data0, 64'hACE1_0001_ACE1_0001);
    do_reset();
    check("block_cleared", 64'(blk0), 64'h0);

    random_phase(300, 75);

    // Drain
    InValid = 1'b0; KeyValid = 1'b0; OutReady = 1'b1;
    repeat (5) tick();
    check("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
